// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
//   Shared definitions for the shift request arbiter and its helpers:
//   datapath widths, direction/fill encodings, the output-slot state type
//   and a behavioural 8-bit barrel shifter used in place of the shifter core.
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam int DW  = 8;   // operand / result width
    localparam int SAW = 3;   // shift-amount width (0..7)

    // Direction encoding carried on req_lr
    localparam logic SH_LEFT  = 1'b1;
    localparam logic SH_RIGHT = 1'b0;

    // Right-shift fill encoding carried on req_al
    localparam logic SH_ARITH = 1'b1;
    localparam logic SH_LOGIC = 1'b0;

    // Output slot occupancy
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Behavioural stand-in for the 8-bit barrel shifter core.
    // Left shifts always zero-fill; the fill select only matters going right.
    function automatic logic [DW-1:0] barrel_shift(
        input logic [DW-1:0]  din,
        input logic [SAW-1:0] shamt,
        input logic           lr,
        input logic           al
    );
        logic signed [DW-1:0] sdin;
        logic signed [DW-1:0] sres;
        sdin = signed'(din);
        sres = sdin >>> shamt;
        if (lr == SH_LEFT)
            return din << shamt;
        else if (al == SH_ARITH)
            return unsigned'(sres);
        else
            return din >> shamt;
    endfunction

endpackage : shift_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin first-one finder. Starting at index ptr and
//   wrapping modulo NREQ, the first set bit of req wins.
//
//   Ports:
//     req    in   NREQ  candidate request vector
//     ptr    in   IDW   highest-priority index for this decision
//     grant  out  NREQ  one-hot winner (all zero when req is zero)
//     idx    out  IDW   binary index of the winner (0 when req is zero)
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    // Walk priority distances from farthest to nearest so the nearest
    // valid requester (smallest distance from ptr) is the last one written.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (i == ((int'(ptr) + k) % NREQ))) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    idx      = i[IDW-1:0];
                end
            end
        end
    end

endmodule : rr_pick

// File: rtl/shift_req_arbiter.sv
// ----------------------------------------------------------------------------
// shift_req_arbiter
//   Shares one combinational 8-bit barrel shifter between NREQ requesters.
//   Requesters are granted round-robin; the granted operation goes through
//   the shifter and its result lands in a single registered output slot
//   with valid/ready backpressure and the producing requester's ID.
//   The slot drains and refills in the same cycle, so a consumer holding
//   out_ready high sees one result per cycle.
//
//   Parameters:
//     NREQ  number of requesters (2..4)
//     IDW   width of out_id, 2**IDW >= NREQ
//
//   Ports:
//     clk        in   1       system clock, rising edge
//     rst        in   1       asynchronous active-high reset
//     req_valid  in   NREQ    per-requester command valid
//     req_ready  out  NREQ    per-requester accept, one-hot or zero
//     req_din    in   8*NREQ  operand, slice i belongs to requester i
//     req_shamt  in   3*NREQ  shift amount 0..7 per requester
//     req_lr     in   NREQ    1 = left, 0 = right
//     req_al     in   NREQ    right fill: 1 = arithmetic, 0 = logical
//     out_valid  out  1       result slot occupied
//     out_ready  in   1       consumer accepts the result
//     out_dout   out  8       shifted result
//     out_id     out  IDW     requester that produced the result
//     busy_cnt   out  8       saturating count of stalled request cycles
// ----------------------------------------------------------------------------
module shift_req_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [DW*NREQ-1:0]  req_din,
    input  logic [SAW*NREQ-1:0] req_shamt,
    input  logic [NREQ-1:0]     req_lr,
    input  logic [NREQ-1:0]     req_al,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_dout,
    output logic [IDW-1:0]      out_id,
    output logic [7:0]          busy_cnt
);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Stall statistic sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    // Pointer moves to the requester just after the winner, modulo NREQ.
    function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] win);
        logic [IDW-1:0] last_idx;
        last_idx = IDW'(NREQ - 1);
        return (win == last_idx) ? '0 : win + IDW'(1);
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    slot_state_e     state;
    logic [IDW-1:0]  rr_ptr;
    logic            vld_p1;
    logic [DW-1:0]   dout_p1;
    logic [IDW-1:0]  id_p1;
    logic [7:0]      stall_cnt;

    // ------------------------------------------------------------------
    // Stage p0: slot availability, arbitration, operand mux, shift
    // ------------------------------------------------------------------
    logic            slot_free_p0;
    logic [NREQ-1:0] pick_req_p0;
    logic [NREQ-1:0] grant_vec_p0;
    logic [IDW-1:0]  grant_idx_p0;
    logic            grant_p0;
    logic            stall_p0;
    logic [DW-1:0]   sel_din_p0;
    logic [SAW-1:0]  sel_shamt_p0;
    logic            sel_lr_p0;
    logic            sel_al_p0;
    logic [DW-1:0]   shift_p0;

    // A full slot can still take a new result when it is being drained in
    // the same cycle.
    assign slot_free_p0 = (state == EMPTY) || out_ready;

    // Masking the candidates (rather than the grant) keeps req_ready and
    // the internal grant strictly identical; reset forces it to zero.
    assign pick_req_p0 = (rst || !slot_free_p0) ? '0 : req_valid;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (pick_req_p0),
        .ptr   (rr_ptr),
        .grant (grant_vec_p0),
        .idx   (grant_idx_p0)
    );

    assign req_ready = grant_vec_p0;
    assign grant_p0  = |grant_vec_p0;
    assign stall_p0  = (|req_valid) && !grant_p0;

    // Steer the winner's command onto the shared shifter inputs.
    always_comb begin
        sel_din_p0   = '0;
        sel_shamt_p0 = '0;
        sel_lr_p0    = 1'b0;
        sel_al_p0    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_p0 == i[IDW-1:0]) begin
                sel_din_p0   = req_din[i*DW +: DW];
                sel_shamt_p0 = req_shamt[i*SAW +: SAW];
                sel_lr_p0    = req_lr[i];
                sel_al_p0    = req_al[i];
            end
        end
    end

    assign shift_p0 = barrel_shift(sel_din_p0, sel_shamt_p0, sel_lr_p0, sel_al_p0);

    // ------------------------------------------------------------------
    // Stage p1: output slot, round-robin pointer, stall counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            rr_ptr    <= '0;
            vld_p1    <= 1'b0;
            dout_p1   <= '0;
            id_p1     <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall_p0)
                stall_cnt <= sat_inc8(stall_cnt);

            if (grant_p0) begin
                state   <= FULL;
                vld_p1  <= 1'b1;
                dout_p1 <= shift_p0;
                id_p1   <= grant_idx_p0;
                rr_ptr  <= ptr_after(grant_idx_p0);
            end else if (state == FULL && out_ready) begin
                // Drained with nothing to refill: data and ID keep their
                // last values, only the slot empties.
                state  <= EMPTY;
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_dout  = dout_p1;
    assign out_id    = id_p1;
    assign busy_cnt  = stall_cnt;

endmodule : shift_req_arbiter

// File: tb/tb_shift_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_shift_req_arbiter
//   Directed bench for shift_req_arbiter (NREQ=2). Expected results are
//   queued when a grant is seen; a negedge monitor pops and compares on
//   every output handshake.
// ----------------------------------------------------------------------------
module tb_shift_req_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_din;
    logic [5:0]  req_shamt;
    logic [1:0]  req_lr;
    logic [1:0]  req_al;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_dout;
    logic [1:0]  out_id;
    logic [7:0]  busy_cnt;

    int errors = 0;
    int checks = 0;

    logic [9:0] exp_q[$];   // {dout, id}
    logic [9:0] sb_exp;

    shift_req_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_din   (req_din),
        .req_shamt (req_shamt),
        .req_lr    (req_lr),
        .req_al    (req_al),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dout  (out_dout),
        .out_id    (out_id),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_cmd(input int i, input logic [7:0] din, input logic [2:0] sh,
                           input logic lr, input logic al);
        if (i == 0) begin
            req_din[7:0]   = din;
            req_shamt[2:0] = sh;
            req_lr[0]      = lr;
            req_al[0]      = al;
        end else begin
            req_din[15:8]  = din;
            req_shamt[5:3] = sh;
            req_lr[1]      = lr;
            req_al[1]      = al;
        end
    endtask

    // Present one command while the slot can accept; it must be granted in
    // the same cycle. Called just after a rising edge.
    task automatic issue_one(input int i, input logic [7:0] din, input logic [2:0] sh,
                             input logic lr, input logic al, input logic [7:0] exp,
                             input string name);
        logic [1:0] onehot;
        logic [1:0] id;
        onehot = (i == 0) ? 2'b01 : 2'b10;
        id     = (i == 0) ? 2'd0 : 2'd1;
        set_cmd(i, din, sh, lr, al);
        req_valid = onehot;
        @(negedge clk);
        check({name, " ready"}, req_ready, onehot);
        exp_q.push_back({exp, id});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
    endtask

    // Scoreboard monitor: one pop per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got dout=%02h id=%0d expected no result",
                         out_dout, out_id);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({out_dout, out_id} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got dout=%02h id=%0d expected dout=%02h id=%0d",
                             out_dout, out_id, sb_exp[9:2], sb_exp[1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_din   = '0;
        req_shamt = '0;
        req_lr    = '0;
        req_al    = '0;
        out_ready = 1'b1;

        // Reset state, requests present during reset must not be accepted
        repeat (2) @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check("rst out_valid", out_valid, 0);
        check("rst out_dout", out_dout, 0);
        check("rst out_id", out_id, 0);
        check("rst busy_cnt", busy_cnt, 0);
        check("rst req_ready", req_ready, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 2'b00;
        @(posedge clk);
        #1;

        // Test 1: single left shift, latency one
        issue_one(0, 8'hB4, 3'd2, 1'b1, 1'b0, 8'hD0, "t1");
        @(negedge clk);
        check("t1 out_valid", out_valid, 1);
        check("t1 out_dout", out_dout, 8'hD0);
        check("t1 out_id", out_id, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1 drained", out_valid, 0);
        check("t1 hold dout", out_dout, 8'hD0);
        @(posedge clk);
        #1;

        // Test 2: requester 1 shift modes and boundaries
        issue_one(1, 8'h90, 3'd3, 1'b0, 1'b1, 8'hF2, "t2 asr3");
        issue_one(1, 8'h90, 3'd3, 1'b0, 1'b0, 8'h12, "t2 lsr3");
        issue_one(1, 8'h90, 3'd0, 1'b0, 1'b1, 8'h90, "t2 sh0");
        issue_one(1, 8'h80, 3'd7, 1'b0, 1'b1, 8'hFF, "t2 asr7");
        issue_one(1, 8'h80, 3'd7, 1'b0, 1'b0, 8'h01, "t2 lsr7");
        issue_one(1, 8'hFF, 3'd7, 1'b1, 1'b1, 8'h80, "t2 lsl7");
        repeat (2) @(posedge clk);
        #1;

        // Test 3: both valid, continuous drain -> alternating grants
        set_cmd(0, 8'h81, 3'd1, 1'b1, 1'b0);   // -> 02
        set_cmd(1, 8'h81, 3'd1, 1'b0, 1'b1);   // -> C0
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3 grant", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            if (k > 0)
                check("t3 no bubble", out_valid, 1);
            exp_q.push_back((k % 2 == 1) ? {8'hC0, 2'd1} : {8'h02, 2'd0});
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("t3 last valid", out_valid, 1);
        check("t3 busy_cnt", busy_cnt, 0);
        repeat (2) @(posedge clk);
        #1;

        // Test 4: backpressure for 5 cycles, then drain and refill together
        out_ready = 1'b0;
        req_valid = 2'b11;
        @(negedge clk);
        check("t4 first grant", req_ready, 2'b01);
        exp_q.push_back({8'h02, 2'd0});
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4 stall ready", req_ready, 2'b00);
            check("t4 hold dout", out_dout, 8'h02);
        end
        @(posedge clk);
        #1;
        check("t4 busy_cnt", busy_cnt, 5);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 refill grant", req_ready, 2'b10);
        exp_q.push_back({8'hC0, 2'd1});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("t4 refill valid", out_valid, 1);
        check("t4 busy after", busy_cnt, 5);
        repeat (2) @(posedge clk);
        #1;

        // Test 5: long stall saturates the counter; this result is later
        // discarded by reset, so it is not queued
        out_ready = 1'b0;
        set_cmd(0, 8'h7F, 3'd7, 1'b1, 1'b0);   // -> 80
        req_valid = 2'b01;
        @(negedge clk);
        check("t5 grant", req_ready, 2'b01);
        repeat (300) @(posedge clk);
        #1;
        check("t5 busy sat", busy_cnt, 8'hFF);
        check("t5 hold dout", out_dout, 8'h80);
        check("t5 hold valid", out_valid, 1);
        @(posedge clk);
        #1;
        check("t5 busy still sat", busy_cnt, 8'hFF);

        // Test 6: reset while full with requests pending; pointer restarts
        req_valid = 2'b11;
        rst       = 1'b1;
        #1;
        check("t6 out_valid", out_valid, 0);
        check("t6 req_ready", req_ready, 2'b00);
        check("t6 busy_cnt", busy_cnt, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6 rr restart", req_ready, 2'b01);
        exp_q.push_back({8'h80, 2'd0});
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        check("sb drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_shift_req_arbiter

// File: doc/shift_req_arbiter.md
Name: shift_req_arbiter

Overview:
- Shares one combinational 8-bit barrel shifter between NREQ requesters.
- Each requester has its own valid/ready channel. Grants are round-robin.
- The chosen operation is driven through the shared shifter, and the result is registered into a single output slot. The slot carries valid/ready backpressure and a requester ID.
- Sits between the ALU-side command sources and the shifter datapath. It is the only block allowed to drive the shifter's control inputs.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the output ID field; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester command valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_din  in  8*NREQ  operand; slice i belongs to requester i.
- req_shamt  in  3*NREQ  shift amount 0..7 per requester.
- req_lr  in  NREQ  direction: 1 = left, 0 = right.
- req_al  in  NREQ  right-shift fill: 1 = arithmetic (sign fill), 0 = logical (zero fill). Ignored for left shifts, which always zero-fill.
- out_valid  out  1  result slot occupied.
- out_ready  in  1  consumer accepts the result.
- out_dout  out  8  shifted result.
- out_id  out  IDW  index of the requester that produced the result.
- busy_cnt  out  8  saturating count of cycles on which some req_valid was high but nothing was granted (stall statistic).

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_dout=0, out_id=0, busy_cnt=0.
  - Round-robin pointer rr_ptr=0.
  - FSM in EMPTY.
- req_ready is purely combinational from state, req_valid, rr_ptr and out_ready. It is all-zero while rst is high.
- FSM states:
  - EMPTY: slot free.
  - FULL: slot holds an unconsumed result.
- Slot can accept this cycle when (state==EMPTY) or (state==FULL and out_ready==1). This gives pass-through drain and refill, so throughput is 1 op/cycle under continuous out_ready.
- Grant, when the slot can accept and any req_valid is high:
  - Search from index rr_ptr upward, wrapping modulo NREQ; the first valid requester g wins.
  - req_ready[g]=1 and all other bits are 0.
- On grant at edge t:
  - Shifter inputs are muxed from requester g combinationally.
  - out_dout <= shifter output; out_id <= g; out_valid=1 from cycle t+1 (latency 1).
  - rr_ptr <= (g+1) mod NREQ.
  - FSM -> FULL.
- FULL, out_ready=1, no grant: out_valid <= 0, FSM -> EMPTY. out_dout and out_id hold their last values.
- FULL, out_ready=0: all outputs hold and req_ready=0. Command inputs may change freely; nothing is sampled.
- rr_ptr advances only on a grant, never on idle cycles.
- Shift arithmetic:
  - Left: dout = din << shamt, zero fill.
  - Right logical: din >> shamt.
  - Right arithmetic: sign-extended din >>> shamt.
  - shamt=0 returns din unchanged in all modes.
- busy_cnt increments when |req_valid and no req_ready bit is set. It saturates at 255.
- Reset asserted mid-operation: the slot contents and pending grant are discarded immediately. The in-flight result is lost and requesters must re-present.
- A requester must hold its command stable while req_valid=1 and req_ready=0. The block does not check this.

Decomposition:
- Shared package shift_pkg holds:
  - constants SH_LEFT=1, SH_RIGHT=0, SH_ARITH=1, SH_LOGIC=0;
  - localparam DW=8, SAW=3;
  - FSM enum {EMPTY, FULL}.
- One sub-module, rr_pick: combinational round-robin first-one finder. Inputs are req vector and ptr; outputs are grant one-hot plus index.
- The shifter core instantiated inside is the team's existing 8-bit barrel shifter. If that core is unavailable during bring-up, a behavioural function in shift_pkg substitutes.

Test Plan:
1. Reset, then a single requester 0: din=8'hB4, shamt=2, lr=1 -> req_ready[0] same cycle; next cycle out_valid=1, out_dout=8'hD0, out_id=0.
2. Requester 1 right arithmetic: din=8'h90, shamt=3, al=1 -> out_dout=8'hF2. Repeat with al=0 -> 8'h12. With shamt=0 -> 8'h90.
3. Both requesters valid continuously, out_ready=1 -> grants alternate 0,1,0,1 on consecutive cycles; out_id sequence 0,1,0,1; no bubbles; busy_cnt stays 0.
4. out_ready=0 for 5 cycles with both valid -> slot holds its first result, req_ready=0, busy_cnt=5. On out_ready=1, the next grant and drain happen in the same cycle.
5. Stall longer than 255 cycles -> busy_cnt saturates at 255, no wrap to 0.
6. rst pulsed while FULL and requests pending -> out_valid=0, req_ready=0 and rr_ptr=0 immediately. After release, requester 0 wins first even if the previous grant was 0.
